hex_display_arbiter: RTL

- Shares the board's six 7-segment digits (hex5..hex0) between two requesters; each requester presents a 24-bit value shown as six hex digits.
- Round-robin arbiter with a guaranteed minimum hold time per grant.
- Converts the granted value to active-low segment codes.
- Sits between user datapaths (counters, switch logic) and the board's hex outputs.

---
 rtl/hex_display_arbiter_if.sv | 24 ++
 rtl/hex_display_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/hex_display_arbiter_if.sv
// Requester/display bundle for hex_display_arbiter: request levels, the two
// 24-bit values, and the grant plus the six active-low segment outputs.
interface hex_display_arbiter_if;
  logic [1:0]  req;
  logic [23:0] data0;
  logic [23:0] data1;
  logic [1:0]  grant;
  logic [6:0]  hex0;
  logic [6:0]  hex1;
  logic [6:0]  hex2;
  logic [6:0]  hex3;
  logic [6:0]  hex4;
  logic [6:0]  hex5;

  modport master (
    output req, data0, data1,
    input  grant, hex0, hex1, hex2, hex3, hex4, hex5
  );

  modport slave (
    input  req, data0, data1,
    output grant, hex0, hex1, hex2, hex3, hex4, hex5
  );
endinterface

// File: rtl/hex_display_arbiter.sv
// Round-robin owner of the six 7-segment digits with a minimum hold per grant;
// the owner's 24-bit value is shown as six active-low hex digits.
//
// state | meaning
// IDLE  | nobody owns the display, digits blank
// SHOW0 | requester 0 owns the display
// SHOW1 | requester 1 owns the display
module hex_display_arbiter #(
  parameter int HOLD_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic                   clock,
  input  logic                   reset_n,
  hex_display_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW0 = 2'd1,
    SHOW1 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [6:0]       BLANK    = 7'h7F;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ptr_q, ptr_d;
  logic [6:0]       hex_q [6];
  logic [6:0]       hex_d [6];
  logic             expired;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign expired = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req == 2'b01)      state_d = SHOW0;
        else if (bus.req == 2'b10) state_d = SHOW1;
        else if (bus.req == 2'b11) state_d = ptr_q ? SHOW1 : SHOW0;
      end
      SHOW0: begin
        // An owner drop wins over expiry so a released display never lingers.
        if (!bus.req[0])                state_d = bus.req[1] ? SHOW1 : IDLE;
        else if (expired && bus.req[1]) state_d = SHOW1;
      end
      SHOW1: begin
        if (!bus.req[1])                state_d = bus.req[0] ? SHOW0 : IDLE;
        else if (expired && bus.req[0]) state_d = SHOW0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_d == SHOW0)      ptr_d = 1'b1;
      else if (state_d == SHOW1) ptr_d = 1'b0;
    end else if (state_q != IDLE && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Encoding keys off the next state so the digits change on the grant edge.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      hex_d[i] = BLANK;
      if (state_d == SHOW0)      hex_d[i] = seg7(bus.data0[i*4 +: 4]);
      else if (state_d == SHOW1) hex_d[i] = seg7(bus.data1[i*4 +: 4]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      for (int i = 0; i < 6; i++) hex_q[i] <= BLANK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      for (int i = 0; i < 6; i++) hex_q[i] <= hex_d[i];
    end
  end

  assign bus.grant = {state_q == SHOW1, state_q == SHOW0};
  assign bus.hex0  = hex_q[0];
  assign bus.hex1  = hex_q[1];
  assign bus.hex2  = hex_q[2];
  assign bus.hex3  = hex_q[3];
  assign bus.hex4  = hex_q[4];
  assign bus.hex5  = hex_q[5];

endmodule
